des_round_key_scheduler: RTL

//  DES key-schedule sequencer that consumes the permuted-choice-1 halves C0/D0 (28 b each) produced by Key_Generation.

---
 rtl/des_round_key_scheduler.sv | 134 +++++++++++++
 1 files changed

// File: rtl/des_round_key_scheduler.sv
// DES round-key sequencer: walks C/D through the shift schedule and presents PC-2
// subkeys one per handshake, K1..K16 (left rotations) or K16..K1 (right rotations).
module des_round_key_scheduler #(
  parameter bit USE_READY  = 1'b1,
  parameter int NUM_ROUNDS = 16
) (
  input  logic        CLK,
  input  logic        RESET_BAR,
  input  logic        START,
  input  logic        DECRYPT,
  input  logic [28:1] LEFT_CIRCULAR_SHIFT1,
  input  logic [28:1] RIGHT_CIRCULAR_SHIFT1,
  output logic [48:1] SUBKEY,
  output logic        SUBKEY_VALID,
  input  logic        SUBKEY_READY,
  output logic [3:0]  ROUND_NUMBER,
  output logic        BUSY,
  output logic        DONE
);

  typedef enum logic {IDLE = 1'b0, RUN = 1'b1} state_e;

  localparam logic [4:0] LAST_CNT = 5'(NUM_ROUNDS);

  localparam int PC2_TBL [48] = '{
    14, 17, 11, 24,  1,  5,  3, 28, 15,  6, 21, 10,
    23, 19, 12,  4, 26,  8, 16,  7, 27, 20, 13,  2,
    41, 52, 31, 37, 47, 55, 30, 40, 51, 45, 33, 48,
    44, 49, 39, 56, 34, 53, 46, 42, 50, 36, 29, 32
  };

  state_e      state_q;
  logic [28:1] c_q, d_q, c_d, d_d;
  logic [4:0]  cnt_q;
  logic        dec_q;
  logic        done_q;

  logic [28:1] c_r1, d_r1, c_r2, d_r2;
  logic [4:0]  nxt_rnd;
  logic        xfer;

  // Index n moves to n-1 (left) or n+1 (right), wrapping between 1 and 28.
  function automatic logic [28:1] rol1(input logic [28:1] x);
    return {x[1], x[28:2]};
  endfunction

  function automatic logic [28:1] ror1(input logic [28:1] x);
    return {x[27:1], x[28]};
  endfunction

  // Rounds 1, 2, 9 and 16 shift by one; every other round shifts by two.
  function automatic logic two_step(input logic [4:0] rnd);
    return !(rnd == 5'd1 || rnd == 5'd2 || rnd == 5'd9 || rnd == 5'd16);
  endfunction

  assign SUBKEY_VALID = (state_q == RUN);
  assign BUSY         = (state_q == RUN);
  assign DONE         = done_q;
  assign xfer         = SUBKEY_VALID && (SUBKEY_READY || !USE_READY);

  // Decrypt undoes the shift of the key just emitted, i.e. SHIFT[17-CNT].
  assign nxt_rnd = dec_q ? (5'd17 - cnt_q) : (cnt_q + 5'd1);

  assign c_r1 = dec_q ? ror1(c_q)  : rol1(c_q);
  assign d_r1 = dec_q ? ror1(d_q)  : rol1(d_q);
  assign c_r2 = dec_q ? ror1(c_r1) : rol1(c_r1);
  assign d_r2 = dec_q ? ror1(d_r1) : rol1(d_r1);

  assign ROUND_NUMBER = (state_q != RUN) ? 4'd0 :
                        dec_q            ? 4'(5'd16 - cnt_q) :
                                           4'(cnt_q - 5'd1);

  always_comb begin
    c_d = c_q;
    d_d = d_q;
    if (state_q == IDLE) begin
      if (START) begin
        // Total rotation over 16 rounds is 28, so C16/D16 equal C0/D0.
        c_d = DECRYPT ? LEFT_CIRCULAR_SHIFT1  : rol1(LEFT_CIRCULAR_SHIFT1);
        d_d = DECRYPT ? RIGHT_CIRCULAR_SHIFT1 : rol1(RIGHT_CIRCULAR_SHIFT1);
      end
    end else if (xfer && cnt_q != LAST_CNT) begin
      c_d = two_step(nxt_rnd) ? c_r2 : c_r1;
      d_d = two_step(nxt_rnd) ? d_r2 : d_r1;
    end
  end

  always_ff @(posedge CLK or negedge RESET_BAR) begin
    if (!RESET_BAR) begin
      state_q <= IDLE;
      c_q     <= '0;
      d_q     <= '0;
      cnt_q   <= '0;
      dec_q   <= 1'b0;
      done_q  <= 1'b0;
    end else begin
      c_q    <= c_d;
      d_q    <= d_d;
      done_q <= 1'b0;
      case (state_q)
        IDLE: begin
          if (START) begin
            state_q <= RUN;
            cnt_q   <= 5'd1;
            dec_q   <= DECRYPT;
          end
        end
        RUN: begin
          if (xfer) begin
            if (cnt_q == LAST_CNT) begin
              state_q <= IDLE;
              cnt_q   <= '0;
              done_q  <= 1'b1;
            end else begin
              cnt_q <= cnt_q + 5'd1;
            end
          end
        end
        default: state_q <= IDLE;
      endcase
    end
  end

  // PC-2 is pure wiring: CD[1..28] = C, CD[29..56] = D.
  for (genvar n = 1; n <= 48; n++) begin : g_pc2
    localparam int P = PC2_TBL[n-1];
    if (P <= 28) begin : g_c
      assign SUBKEY[n] = c_q[P];
    end else begin : g_d
      assign SUBKEY[n] = d_q[P-28];
    end
  end

endmodule
